cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step controller that sequences the pipelined CPU core through a clock-enable rather than a hand-toggled debug clock. It accepts commands from the debug VIO (halt, single-step, run N cycles, run to breakpoint) and gates `cpu_ce` into `CPU_pipe`. It stops the core on a cycle count, a PC breakpoint, or a nonzero `scause`, and reports why it stopped and how many cycles ran.

## Interface
- `CNT_W`, 16, width of run count and cycle counter
- `clk`  input  1  system clock; core and memories run on this clock, gated by `cpu_ce`
- `rst`  input  1  asynchronous, active-low reset
- `cmd_valid`  input  1  command present
- `cmd_ready`  output  1  command accepted when `cmd_valid && cmd_ready` at the rising edge
- `cmd_op`  input  2  00 HALT, 01 STEP, 10 RUN_N, 11 RUN_BP
- `cmd_count`  input  CNT_W  cycle count for RUN_N; sampled at accept
- `bp_en`  input  1  breakpoint enable; sampled at accept
- `bp_addr`  input  32  breakpoint PC; sampled at accept
- `pc`  input  32  current PC from core
- `scause`  input  5  core error cause; nonzero means error
- `cpu_ce`  output  1  core clock enable
- `busy`  output  1  state is not IDLE
- `done`  output  1  one-cycle pulse on return to IDLE
- `stop_reason`  output  2  00 halt command, 01 count exhausted or step complete, 10 breakpoint, 11 error; held until next accept
- `cycles_run`  output  CNT_W  cycles with `cpu_ce`=1 since last accept; saturating
- `cmd_drop`  output  1  one-cycle pulse when a non-HALT command arrives while busy

## Operation
- FSM states: IDLE, STEP, RUN_N, RUN_BP.
- `cmd_ready` is always 1.
  - In IDLE, every op is accepted.
  - In other states, only HALT takes effect. Other ops are discarded and pulse `cmd_drop` the next cycle.
- Accept clears `cycles_run` to 0. It latches `cmd_count`, `bp_en` and `bp_addr` into internal registers.
- Transitions on accept from IDLE:
  - HALT: stays IDLE, `stop_reason`=00, `done` pulses.
  - STEP: goes to STEP.
  - RUN_N with count 0: stays IDLE, `stop_reason`=01, `done` pulses, `cpu_ce` never asserts.
  - RUN_N with count ≥1: goes to RUN_N, remaining count = `cmd_count`.
  - RUN_BP: goes to RUN_BP.
- Stop conditions, evaluated combinationally each cycle in STEP/RUN_N/RUN_BP:
  - err = (`scause` != 0).
  - bp = latched `bp_en` && `pc` == latched `bp_addr` && not first cycle of the run. The first cycle is exempt so a run can resume from a breakpoint.
  - The breakpoint applies in RUN_N and RUN_BP, not in STEP.
- `cpu_ce` = (state != IDLE) && !err && !bp.
  - Because it is combinational, the instruction at the breakpoint PC is never clocked.
- When a stop condition is true, the next state is IDLE with `done` pulsed.
  - Reason priority: err (11) over bp (10).
- STEP: `cpu_ce` is 1 for exactly one cycle (unless err), then IDLE with reason 01.
- RUN_N: each `cpu_ce` cycle decrements the remaining count. When remaining reaches 0, go to IDLE with reason 01.
- RUN_BP with `bp_en`=0 runs until err or HALT.
- HALT while busy: `cpu_ce` goes low in the accept cycle's successor. State goes to IDLE with reason 00.
  - HALT has priority over a simultaneous count/bp/err stop in the same cycle.
- `cycles_run` increments on every `cpu_ce`=1 cycle and saturates at 2^CNT_W−1.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - state IDLE, `cpu_ce` 0, `busy` 0, `done` 0, `cmd_drop` 0, `stop_reason` 00, `cycles_run` 0.
  - Latched count, `bp_en` and `bp_addr` are 0.
  - `cmd_ready` is 1.
- Reset mid-run drops `cpu_ce` immediately, without a clock edge, and produces no `done` pulse.
- Accept at edge T: `busy`=1 and the first `cpu_ce` cycle is T+1.
- RUN_N with count N and no stops:
  - `cpu_ce` is high for cycles T+1..T+N.
  - `done`=1 and `busy`=0 in cycle T+N+1.
  - `cycles_run`=N.
- STEP: `cpu_ce` high in T+1, `done` in T+2.
- Stop on err/bp in cycle S: `cpu_ce`=0 in S, `done`=1 in S+1.
- All outputs except `cpu_ce` are registered.

## Test plan
- Reset then STEP at pc=0x0 → `cpu_ce` high exactly 1 cycle, `done` next cycle, `stop_reason`=01, `cycles_run`=1.
- RUN_N count=5 with `scause`=0 and `bp_en`=0 → 5 consecutive `cpu_ce` cycles, `cycles_run`=5, `stop_reason`=01.
- RUN_BP with `bp_addr`=0x10; `pc` steps 0x8, 0xC, 0x10 → `cpu_ce` low in the cycle `pc`=0x10, `stop_reason`=10, `cycles_run`=2. Then a new RUN_BP with `pc` still 0x10 → not stopped on its first cycle.
- RUN_N count=100; `scause`=5'h02 at cycle 7 → `cpu_ce` low that cycle, `stop_reason`=11, `cycles_run`=6. Then HALT sent during a run → stops next cycle with reason 00, and a STEP sent while busy pulses `cmd_drop`.
- RUN_N count=0 → no `cpu_ce`, immediate `done`, reason 01.
- `rst` low mid-RUN_N → `cpu_ce` drops asynchronously and all outputs return to reset values.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Purpose: run/step controller that gates the CPU core through a clock enable.
// Latency: commands accepted at edge T give the first cpu_ce cycle at T+1; done follows one cycle after the stop.
// Backpressure: cmd_ready is always high; non-HALT commands arriving while busy are dropped and flagged via cmd_drop.
module cpu_run_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [4:0]       scause,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic [1:0]       stop_reason,
    output logic [CNT_W-1:0] cycles_run,
    output logic             cmd_drop
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_STEP   = 2'b01,
        S_RUN_N  = 2'b10,
        S_RUN_BP = 2'b11
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_STEP   = 2'b01;
    localparam logic [1:0] OP_RUN_N  = 2'b10;
    localparam logic [1:0] OP_RUN_BP = 2'b11;

    localparam logic [1:0] RSN_HALT = 2'b00;
    localparam logic [1:0] RSN_CNT  = 2'b01;
    localparam logic [1:0] RSN_BP   = 2'b10;
    localparam logic [1:0] RSN_ERR  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    logic [CNT_W-1:0] rem_cnt;
    logic             bp_en_q;
    logic [31:0]      bp_addr_q;
    logic             first_q;

    logic             active;
    logic             err_stop;
    logic             bp_stop;
    logic             halt_req;
    logic [CNT_W-1:0] cycles_inc;

    assign cmd_ready = 1'b1;

    // Stop detection is combinational so the core never gets clocked on a stopping cycle.
    // The first cycle of a run is exempt from the breakpoint so a run can resume from it.
    always_comb begin
        active     = (state != S_IDLE);
        err_stop   = active && (scause != 5'd0);
        bp_stop    = ((state == S_RUN_N) || (state == S_RUN_BP)) && bp_en_q &&
                     (pc == bp_addr_q) && !first_q;
        cpu_ce     = active && !err_stop && !bp_stop;
        halt_req   = cmd_valid && (cmd_op == OP_HALT);
        cycles_inc = (&cycles_run) ? cycles_run : cycles_run + CNT_ONE;
    end

    // Run/step state machine with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rem_cnt     <= CNT_ZERO;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= 32'd0;
            first_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_drop    <= 1'b0;
            stop_reason <= RSN_HALT;
            cycles_run  <= CNT_ZERO;
        end else begin
            done     <= 1'b0;
            cmd_drop <= 1'b0;
            if (!active) begin
                if (cmd_valid) begin
                    rem_cnt    <= cmd_count;
                    bp_en_q    <= bp_en;
                    bp_addr_q  <= bp_addr;
                    first_q    <= 1'b1;
                    cycles_run <= CNT_ZERO;
                    unique case (cmd_op)
                        OP_HALT: begin
                            stop_reason <= RSN_HALT;
                            done        <= 1'b1;
                        end
                        OP_STEP: begin
                            state <= S_STEP;
                            busy  <= 1'b1;
                        end
                        OP_RUN_N: begin
                            if (cmd_count == CNT_ZERO) begin
                                stop_reason <= RSN_CNT;
                                done        <= 1'b1;
                            end else begin
                                state <= S_RUN_N;
                                busy  <= 1'b1;
                            end
                        end
                        OP_RUN_BP: begin
                            state <= S_RUN_BP;
                            busy  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                if (cmd_valid && !halt_req) begin
                    cmd_drop <= 1'b1;
                end
                if (halt_req) begin
                    // HALT outranks any stop condition seen in the same cycle.
                    rem_cnt     <= cmd_count;
                    bp_en_q     <= bp_en;
                    bp_addr_q   <= bp_addr;
                    cycles_run  <= CNT_ZERO;
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    stop_reason <= RSN_HALT;
                end else if (err_stop) begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    stop_reason <= RSN_ERR;
                end else if (bp_stop) begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    stop_reason <= RSN_BP;
                end else begin
                    // cpu_ce is high this cycle.
                    first_q    <= 1'b0;
                    cycles_run <= cycles_inc;
                    unique case (state)
                        S_STEP: begin
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            stop_reason <= RSN_CNT;
                        end
                        S_RUN_N: begin
                            rem_cnt <= rem_cnt - CNT_ONE;
                            if (rem_cnt == CNT_ONE) begin
                                state       <= S_IDLE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                stop_reason <= RSN_CNT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Purpose: scoreboard bench for cpu_run_ctrl driven by directed command vectors.
// Latency: expectations are queued per command and retired by the monitor on each done pulse.
// Backpressure: cmd_ready is expected high always; drop behaviour is probed directly.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [4:0]  scause;
    logic        cpu_ce;
    logic        busy;
    logic        done;
    logic [1:0]  stop_reason;
    logic [15:0] cycles_run;
    logic        cmd_drop;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_count   (cmd_count),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .scause      (scause),
        .cpu_ce      (cpu_ce),
        .busy        (busy),
        .done        (done),
        .stop_reason (stop_reason),
        .cycles_run  (cycles_run),
        .cmd_drop    (cmd_drop)
    );

    typedef struct packed {
        logic [1:0]  reason;
        logic [15:0] cyc;
        logic [31:0] ce;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   ce_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [1:0] reason, input logic [15:0] cyc, input logic [31:0] ce);
        exp_t e;
        e.reason = reason;
        e.cyc    = cyc;
        e.ce     = ce;
        exp_q.push_back(e);
    endtask

    // Presents one command for exactly one accepting edge; returns 1ns into the following cycle.
    task automatic send(input logic [1:0] op, input logic [15:0] cnt, input logic be, input logic [31:0] ba);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        bp_en     = be;
        bp_addr   = ba;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
        end
    endtask

    // Monitor: counts enabled core cycles independently and retires one expectation per done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            ce_cnt = 0;
        end else begin
            if (cpu_ce) ce_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stop_reason", {30'd0, stop_reason}, {30'd0, e.reason});
                    check("cycles_run", {16'd0, cycles_run}, {16'd0, e.cyc});
                    check("ce_cycles", ce_cnt, e.ce);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                end
                ce_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = 16'd0;
        bp_en     = 1'b0;
        bp_addr   = 32'd0;
        pc        = 32'd0;
        scause    = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cycles", {16'd0, cycles_run}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b1;

        // Single step from pc 0.
        push(2'b01, 16'd1, 32'd1);
        send(2'b01, 16'd0, 1'b0, 32'd0);
        check("step_busy", {31'd0, busy}, 32'd1);
        wait_done("step");

        // Run five cycles.
        push(2'b01, 16'd5, 32'd5);
        send(2'b10, 16'd5, 1'b0, 32'd0);
        wait_done("run5");

        // Run to breakpoint 0x10 with pc walking 0x8, 0xC, 0x10.
        pc = 32'h8;
        push(2'b10, 16'd2, 32'd2);
        send(2'b11, 16'd0, 1'b1, 32'h10);
        @(posedge clk); #1; pc = 32'hC;
        @(posedge clk); #1; pc = 32'h10;
        @(negedge clk);
        check("bp_ce_low", {31'd0, cpu_ce}, 32'd0);
        wait_done("run_bp");

        // Resume from the breakpoint PC: first cycle must clock the core.
        push(2'b10, 16'd1, 32'd1);
        send(2'b11, 16'd0, 1'b1, 32'h10);
        @(negedge clk);
        check("bp_resume_ce", {31'd0, cpu_ce}, 32'd1);
        wait_done("bp_resume");

        // Breakpoint also applies in RUN_N.
        pc = 32'h20;
        push(2'b10, 16'd1, 32'd1);
        send(2'b10, 16'd10, 1'b1, 32'h20);
        wait_done("run_n_bp");

        // Error on the 7th cycle of a long run.
        pc = 32'h0;
        push(2'b11, 16'd6, 32'd6);
        send(2'b10, 16'd100, 1'b0, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        scause = 5'h02;
        @(negedge clk);
        check("err_ce_low", {31'd0, cpu_ce}, 32'd0);
        @(posedge clk);
        #1;
        scause = 5'd0;
        wait_done("err");

        // Free run, a dropped STEP while busy, then HALT.
        push(2'b00, 16'd0, 32'd6);
        send(2'b11, 16'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(2'b01, 16'd0, 1'b0, 32'd0);
        check("drop_pulse", {31'd0, cmd_drop}, 32'd1);
        check("drop_still_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("drop_one_cycle", {31'd0, cmd_drop}, 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("halt_ce_low", {31'd0, cpu_ce}, 32'd0);
        wait_done("halt");

        // HALT while idle.
        push(2'b00, 16'd0, 32'd0);
        send(2'b00, 16'd0, 1'b0, 32'd0);
        wait_done("halt_idle");

        // RUN_N with a zero count completes immediately.
        push(2'b01, 16'd0, 32'd0);
        send(2'b10, 16'd0, 1'b0, 32'd0);
        check("run0_done", {31'd0, done}, 32'd1);
        check("run0_ce", {31'd0, cpu_ce}, 32'd0);
        wait_done("run0");

        // Asynchronous reset in the middle of a run.
        send(2'b10, 16'd50, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_ce", {31'd0, cpu_ce}, 32'd1);
        rst = 1'b0;
        #1;
        check("arst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_drop", {31'd0, cmd_drop}, 32'd0);
        check("arst_reason", {30'd0, stop_reason}, 32'd0);
        check("arst_cycles", {16'd0, cycles_run}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Recovery after reset.
        push(2'b01, 16'd1, 32'd1);
        send(2'b01, 16'd0, 1'b0, 32'd0);
        wait_done("step_after_rst");

        repeat (2) @(posedge clk);
        check("exp_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
